maestro_memoria: RTL and testbench



---
 rtl/memoria_pkg.sv | 22 ++
 rtl/contador_rafaga.sv | 18 +
 rtl/maestro_memoria.sv | 160 ++++++++++++++++
 tb/tb_maestro_memoria.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memoria_pkg.sv
// Definitions shared by the memoria memory and the masters that drive it.
// Defining MAESTRO_MEMORIA_CHECK_EN adds the write read-back states.
package memoria_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 14;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_ISSUE,
      RD_CAPT,
      RD_RESP,
      WR_RESP
`ifdef MAESTRO_MEMORIA_CHECK_EN
      ,
      CHK_ISSUE,
      CHK_CAPT
`endif
   } state_t;

endpackage

// File: rtl/contador_rafaga.sv
// Burst bookkeeping: next address with modulo-32 wrap, beat counter, last-beat detect.
module contador_rafaga
   import memoria_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] beat,
   input  logic [ADDR_W-1:0] len,
   output logic [ADDR_W-1:0] addr_next,
   output logic [ADDR_W-1:0] beat_next,
   output logic              last
);

   // The carry out of the ADDR_W-bit sum is dropped, so 31 wraps to 0.
   assign addr_next = addr + 1'b1;
   assign last      = (beat == len);
   assign beat_next = last ? beat : beat + 1'b1;

endmodule

// File: rtl/maestro_memoria.sv
// Burst master for the memoria single-port memory: fill-word write bursts and read bursts.
// Defining MAESTRO_MEMORIA_CHECK_EN re-reads every write burst and flags mismatches on err.
module maestro_memoria
   import memoria_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [ADDR_W-1:0] req_len,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_datain,
   input  logic [DATA_W-1:0] mem_dataout,
   output logic              err
);

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] beat;
   logic [ADDR_W-1:0] len;
   logic [DATA_W-1:0] fill;
   logic [ADDR_W-1:0] addr_next;
   logic [ADDR_W-1:0] beat_next;
   logic              last;
`ifdef MAESTRO_MEMORIA_CHECK_EN
   logic [ADDR_W-1:0] start;
   logic              err_q;
`endif

   contador_rafaga u_contador (
      .addr      (addr),
      .beat      (beat),
      .len       (len),
      .addr_next (addr_next),
      .beat_next (beat_next),
      .last      (last)
   );

   assign mem_address = addr;
   assign mem_datain  = fill;
`ifdef MAESTRO_MEMORIA_CHECK_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // NOTE: mem_en is a register, so a write beat already on the bus at a reset edge still lands in memoria.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_last  <= 1'b0;
         mem_en    <= 1'b0;
         addr      <= '0;
         beat      <= '0;
         len       <= '0;
         fill      <= '0;
`ifdef MAESTRO_MEMORIA_CHECK_EN
         start     <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr      <= req_addr;
                  len       <= req_len;
                  fill      <= req_wdata;
                  beat      <= '0;
                  req_ready <= 1'b0;
`ifdef MAESTRO_MEMORIA_CHECK_EN
                  start     <= req_addr;
`endif
                  if (req_wr) begin
                     state  <= WR;
                     mem_en <= 1'b1;
                  end else begin
                     state  <= RD_ISSUE;
                  end
               end
            end
            WR: begin
               if (last) begin
                  mem_en    <= 1'b0;
`ifdef MAESTRO_MEMORIA_CHECK_EN
                  addr      <= start;
                  beat      <= '0;
                  state     <= CHK_ISSUE;
`else
                  rsp_valid <= 1'b1;
                  rsp_data  <= '0;
                  rsp_last  <= 1'b1;
                  state     <= WR_RESP;
`endif
               end else begin
                  addr <= addr_next;
                  beat <= beat_next;
               end
            end
            RD_ISSUE: state <= RD_CAPT;
            RD_CAPT: begin
               rsp_data  <= mem_dataout;
               rsp_valid <= 1'b1;
               rsp_last  <= last;
               state     <= RD_RESP;
            end
            RD_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_last  <= 1'b0;
                  if (last) begin
                     req_ready <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     addr  <= addr_next;
                     beat  <= beat_next;
                     state <= RD_ISSUE;
                  end
               end
            end
            WR_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_last  <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
`ifdef MAESTRO_MEMORIA_CHECK_EN
            CHK_ISSUE: state <= CHK_CAPT;
            CHK_CAPT: begin
               if (mem_dataout != fill) err_q <= 1'b1;
               if (last) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= '0;
                  rsp_last  <= 1'b1;
                  state     <= WR_RESP;
               end else begin
                  addr  <= addr_next;
                  beat  <= beat_next;
                  state <= CHK_ISSUE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_maestro_memoria.sv
// Self-checking bench for maestro_memoria: directed vector table, mid-burst reset, random bursts.
// The memoria model forces bit 0 low at address 5 when MAESTRO_MEMORIA_CHECK_EN is defined.
module tb_maestro_memoria;
   import memoria_pkg::*;

`ifdef MAESTRO_MEMORIA_CHECK_EN
   localparam bit FAULT_ON = 1'b1;
`else
   localparam bit FAULT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wr;
   logic [4:0]  req_addr, req_len;
   logic [13:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_last;
   logic [13:0] rsp_data;
   logic        mem_en;
   logic [4:0]  mem_address;
   logic [13:0] mem_datain, mem_dataout;
   logic        err;
   logic        mem_clear;

   always #5 clk = ~clk;

   maestro_memoria dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_wr      (req_wr),
      .req_addr    (req_addr),
      .req_len     (req_len),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_last    (rsp_last),
      .mem_en      (mem_en),
      .mem_address (mem_address),
      .mem_datain  (mem_datain),
      .mem_dataout (mem_dataout),
      .err         (err)
   );

   function automatic logic [13:0] mem_view(input logic [13:0] d, input int a);
      logic [13:0] r;
      r = d;
      if (FAULT_ON && a == 5) r[0] = 1'b0;
      return r;
   endfunction

   // memoria: synchronous write on en, registered read one edge after the address
   logic [13:0] mem [32];
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
      end else if (mem_en) begin
         mem[mem_address] <= mem_datain;
      end
      mem_dataout <= mem_view(mem[mem_address], int'(mem_address));
   end

   // reference model state
   logic [13:0] ref_mem [32];
   logic        err_exp;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int wr_lat(input int len);
      if (FAULT_ON) return 1 + 2 * (len + 1);
      return 1;
   endfunction

   // Called at the negedge where a response should be showing; returns just after its transfer edge.
   task automatic take_beat(input string tag, input logic [13:0] exp_d, input logic exp_last, input int stall);
      logic [4:0] a0;
      check({tag, "_valid"}, rsp_valid, 1);
      check({tag, "_data"}, rsp_data, exp_d);
      check({tag, "_last"}, rsp_last, exp_last);
      check({tag, "_busy_ready"}, req_ready, 0);
      if (stall > 0) begin
         rsp_ready = 1'b0;
         a0 = mem_address;
         repeat (stall) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, rsp_valid, 1);
            check({tag, "_stall_data"}, rsp_data, exp_d);
            check({tag, "_stall_last"}, rsp_last, exp_last);
            check({tag, "_stall_addr"}, mem_address, a0);
         end
         rsp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input logic wr, input logic [4:0] addr, input logic [4:0] len,
                          input logic [13:0] wdata, input int stall_beat, input int stall_cyc,
                          input bit noise, input bit use_exp, input logic [13:0] exp_first);
      int cnt;
      int en_seen;
      @(negedge clk);
      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_len   = len;
      req_wdata = wdata;
      @(posedge clk);
      #1;
      if (noise) begin
         req_wr    = ~wr;
         req_addr  = 5'($urandom);
         req_len   = 5'($urandom);
         req_wdata = 14'($urandom);
      end else begin
         req_valid = 1'b0;
      end
      if (wr) begin
         for (int i = 0; i <= int'(len); i++) begin
            int a = (int'(addr) + i) % 32;
            @(negedge clk);
            check("wr_en", mem_en, 1);
            check("wr_addr", mem_address, a);
            check("wr_datain", mem_datain, wdata);
            check("wr_busy_ready", req_ready, 0);
            ref_mem[a] = wdata;
            if (mem_view(wdata, a) != wdata) err_exp = 1'b1;
         end
         cnt = 0;
         en_seen = 0;
         do begin
            @(negedge clk);
            cnt++;
            if (mem_en) en_seen++;
         end while (!rsp_valid && cnt < 200);
         check("wr_rsp_latency", cnt, wr_lat(int'(len)));
         check("wr_extra_en", en_seen, 0);
         req_valid = 1'b0;
         take_beat("wr_rsp", 14'h0, 1'b1, stall_cyc);
      end else begin
         for (int i = 0; i <= int'(len); i++) begin
            int a = (int'(addr) + i) % 32;
            logic [13:0] exp_d;
            exp_d = mem_view(ref_mem[a], a);
            cnt = 0;
            en_seen = 0;
            do begin
               @(negedge clk);
               cnt++;
               if (mem_en) en_seen++;
            end while (!rsp_valid && cnt < 20);
            check("rd_latency", cnt, 3);
            check("rd_no_en", en_seen, 0);
            check("rd_addr", mem_address, a);
            if (i == 0 && use_exp) check("rd_first_table", rsp_data, exp_first);
            if (i == int'(len)) req_valid = 1'b0;
            take_beat("rd", exp_d, i == int'(len), (i == stall_beat) ? stall_cyc : 0);
         end
      end
      @(negedge clk);
      check("done_ready", req_ready, 1);
      check("done_valid", rsp_valid, 0);
      check("done_en", mem_en, 0);
      check("done_err", err, err_exp);
   endtask

   typedef struct {
      logic        wr;
      logic [4:0]  addr;
      logic [4:0]  len;
      logic [13:0] wdata;
      int          stall_beat;
      int          stall_cyc;
      bit          noise;
      bit          use_exp;
      logic [13:0] exp_first;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 5'd4,  5'd0,  14'h3FFF, 0, 0, 1'b0, 1'b0, 14'h0};
      vecs[1] = '{1'b0, 5'd4,  5'd0,  14'h0,    0, 0, 1'b0, 1'b1, 14'h3FFF};
      vecs[2] = '{1'b1, 5'd30, 5'd3,  14'h0155, 0, 0, 1'b0, 1'b0, 14'h0};
      vecs[3] = '{1'b0, 5'd30, 5'd3,  14'h0,    2, 5, 1'b0, 1'b1, 14'h0155};
      vecs[4] = '{1'b1, 5'd0,  5'd31, 14'h2AAA, 0, 2, 1'b1, 1'b0, 14'h0};
      vecs[5] = '{1'b0, 5'd28, 5'd7,  14'h0,    0, 2, 1'b1, 1'b1, 14'h2AAA};
      vecs[6] = '{1'b1, 5'd5,  5'd0,  14'h0001, 0, 0, 1'b0, 1'b0, 14'h0};
      vecs[7] = '{1'b0, 5'd4,  5'd2,  14'h0,    1, 1, 1'b0, 1'b1, 14'h2AAA};

      rst = 1'b1;
      mem_clear = 1'b1;
      req_valid = 1'b0;
      req_wr = 1'b0;
      req_addr = '0;
      req_len = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      err_exp = 1'b0;
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_last", rsp_last, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_address", mem_address, 0);
      check("rst_mem_datain", mem_datain, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      mem_clear = 1'b0;

      for (int v = 0; v < 8; v++)
         run_req(vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].wdata, vecs[v].stall_beat,
                 vecs[v].stall_cyc, vecs[v].noise, vecs[v].use_exp, vecs[v].exp_first);

      // reset on the second beat of a len-7 write
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 5'd10;
      req_len   = 5'd7;
      req_wdata = 14'h1234;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rstmid_beat0_en", mem_en, 1);
      check("rstmid_beat0_addr", mem_address, 10);
      @(negedge clk);
      check("rstmid_beat1_en", mem_en, 1);
      check("rstmid_beat1_addr", mem_address, 11);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstmid_en", mem_en, 0);
      check("rstmid_rsp_valid", rsp_valid, 0);
      check("rstmid_ready", req_ready, 1);
      check("rstmid_addr", mem_address, 0);
      check("rstmid_err", err, 0);
      ref_mem[10] = 14'h1234;
      ref_mem[11] = 14'h1234;
      err_exp = 1'b0;
      run_req(1'b0, 5'd10, 5'd2, 14'h0, 0, 0, 1'b0, 1'b1, 14'h1234);

      for (int r = 0; r < 25; r++) begin
         logic [4:0] len;
         len = 5'($urandom_range(0, 9));
         run_req(1'($urandom), 5'($urandom), len, 14'($urandom), $urandom_range(0, int'(len)),
                 $urandom_range(0, 3), 1'($urandom), 1'b0, 14'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
